sync_edge_filter: RTL and testbench

Parametrised multi-bit clock-domain-crossing input conditioner. Each bit of an asynchronous input bus passes through a STAGES-deep synchronizer flop chain, then an optional per-bit glitch filter. The block emits a filtered level plus single-cycle rise and fall pulses in the clk domain. It sits at the FPGA boundary for GPIO, interrupt and status lines entering clk logic, and supersedes fixed two-flop synchronization where debounce or edge events are needed.

---
 rtl/sync_edge_filter_pkg.sv | 11 +
 rtl/sync_edge_filter_bit.sv | 79 +++++++
 rtl/sync_edge_filter.sv | 48 ++++
 tb/tb_sync_edge_filter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sync_edge_filter_pkg.sv
// rtl/sync_edge_filter_pkg.sv - shared helpers for parametrised width calculations
package sync_edge_filter_pkg;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sync_edge_filter_bit.sv
// rtl/sync_edge_filter_bit.sv - one channel: sync chain, glitch filter, edge pulses
module sync_edge_filter_bit
    import sync_edge_filter_pkg::*;
#(
    parameter int   STAGES  = 2,
    parameter int   FILT    = 1,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall,
    output logic rise_next,
    output logic fall_next
);

    localparam int CW = clog2_min1(FILT);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILT - 1);

    // First flop is the only one that sees the asynchronous input.
    (* ASYNC_REG = "TRUE" *) logic sync_first;
    logic [STAGES-2:0] sync_tail;
    logic [CW-1:0]     cnt;
    logic              s;
    logic              differ;
    logic              upd;

    assign s = sync_tail[STAGES-2];

    // Metastability chain: capture in, then shift through the remaining stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_first <= RST_VAL;
            sync_tail  <= {(STAGES-1){RST_VAL}};
        end else begin
            sync_first   <= in;
            sync_tail[0] <= sync_first;
            for (int k = 1; k < STAGES - 1; k++) begin
                sync_tail[k] <= sync_tail[k-1];
            end
        end
    end

    // Decide whether the synchronized value has differed long enough to be accepted.
    always_comb begin
        differ    = 1'b0;
        upd       = 1'b0;
        rise_next = 1'b0;
        fall_next = 1'b0;
        differ    = (s != out);
        upd       = differ && (cnt == CNT_LAST);
        rise_next = upd & s;
        fall_next = upd & ~s;
    end

    // Filter counter, accepted level and one-cycle edge pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            out  <= RST_VAL;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            if (!differ) begin
                cnt <= '0;
            end else if (upd) begin
                out <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
            rise <= rise_next;
            fall <= fall_next;
        end
    end

endmodule

// File: rtl/sync_edge_filter.sv
// rtl/sync_edge_filter.sv - multi-bit CDC synchronizer with glitch filter and edge pulses
module sync_edge_filter
    import sync_edge_filter_pkg::*;
#(
    parameter int          DW      = 32,
    parameter int          STAGES  = 2,
    parameter int          FILT    = 1,
    parameter logic [DW-1:0] RST_VAL = {DW{1'b0}}
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in,
    output logic [DW-1:0] out,
    output logic [DW-1:0] rise,
    output logic [DW-1:0] fall,
    output logic          changed
);

    logic [DW-1:0] rise_next;
    logic [DW-1:0] fall_next;

    for (genvar i = 0; i < DW; i++) begin : g_bit
        sync_edge_filter_bit #(
            .STAGES  (STAGES),
            .FILT    (FILT),
            .RST_VAL (RST_VAL[i])
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .in        (in[i]),
            .out       (out[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .rise_next (rise_next[i]),
            .fall_next (fall_next[i])
        );
    end

    // Registered from the same next-state terms so changed lines up with rise/fall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            changed <= 1'b0;
        end else begin
            changed <= |(rise_next | fall_next);
        end
    end

endmodule

// File: tb/tb_sync_edge_filter.sv
// tb/tb_sync_edge_filter.sv - directed self-checking bench for sync_edge_filter
module tb_sync_edge_filter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in0 = '0, in1 = '0, in2 = '0, in3 = 32'h0000_00F0;
    logic [31:0] out0, out1, out2, out3;
    logic [31:0] rise0, rise1, rise2, rise3;
    logic [31:0] fall0, fall1, fall2, fall3;
    logic        ch0, ch1, ch2, ch3;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    sync_edge_filter #(.DW(32), .STAGES(2), .FILT(1), .RST_VAL(32'h0)) u0 (
        .clk(clk), .reset(reset), .in(in0), .out(out0), .rise(rise0), .fall(fall0), .changed(ch0));
    sync_edge_filter #(.DW(32), .STAGES(3), .FILT(4), .RST_VAL(32'h0)) u1 (
        .clk(clk), .reset(reset), .in(in1), .out(out1), .rise(rise1), .fall(fall1), .changed(ch1));
    sync_edge_filter #(.DW(32), .STAGES(2), .FILT(8), .RST_VAL(32'h0)) u2 (
        .clk(clk), .reset(reset), .in(in2), .out(out2), .rise(rise2), .fall(fall2), .changed(ch2));
    sync_edge_filter #(.DW(32), .STAGES(2), .FILT(1), .RST_VAL(32'h0000_00F0)) u3 (
        .clk(clk), .reset(reset), .in(in3), .out(out3), .rise(rise3), .fall(fall3), .changed(ch3));

    task automatic test_reset;
        logic [31:0] exp_out, exp_rise;
        logic        exp_ch;
        reset = 1'b1;
        in0 = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out0 !== 32'h0) begin n_fail++; $display("FAIL reset_hold_out got %h exp %h", out0, 32'h0); end
        n_checks++;
        if ((rise0 | fall0) !== 32'h0 || ch0 !== 1'b0) begin
            n_fail++; $display("FAIL reset_hold_pulse got rise %h fall %h ch %b exp 0", rise0, fall0, ch0);
        end
        n_checks++;
        if (out3 !== 32'h0000_00F0) begin n_fail++; $display("FAIL reset_hold_rstval got %h exp %h", out3, 32'h0000_00F0); end
        reset = 1'b0;
        for (int e = 0; e < 6; e++) begin
            @(posedge clk); #1;
            exp_out  = (e >= 2) ? 32'hFFFF_FFFF : 32'h0;
            exp_rise = (e == 2) ? 32'hFFFF_FFFF : 32'h0;
            exp_ch   = (e == 2);
            n_checks++;
            if (out0 !== exp_out || rise0 !== exp_rise || fall0 !== 32'h0 || ch0 !== exp_ch) begin
                n_fail++;
                $display("FAIL reset_release edge %0d got out %h rise %h fall %h ch %b exp out %h rise %h fall 0 ch %b",
                         e, out0, rise0, fall0, ch0, exp_out, exp_rise, exp_ch);
            end
        end
    endtask

    task automatic test_latency;
        logic [31:0] exp_out, exp_rise;
        @(negedge clk);
        in1[5] = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            exp_out  = (e >= 6) ? 32'h20 : 32'h0;
            exp_rise = (e == 6) ? 32'h20 : 32'h0;
            n_checks++;
            if (out1 !== exp_out || rise1 !== exp_rise || fall1 !== 32'h0 || ch1 !== (e == 6)) begin
                n_fail++;
                $display("FAIL latency edge %0d got out %h rise %h fall %h ch %b exp out %h rise %h",
                         e, out1, rise1, fall1, ch1, exp_out, exp_rise);
            end
        end
        @(negedge clk);
        in1[5] = 1'b0;
        repeat (12) @(negedge clk);
        n_checks++;
        if (out1 !== 32'h0) begin n_fail++; $display("FAIL latency_return got %h exp %h", out1, 32'h0); end
    endtask

    task automatic test_glitch;
        int bad, n_rise, n_fall, t_rise, t_fall;
        bad = 0;
        @(negedge clk);
        in1[0] = 1'b1;
        repeat (3) @(negedge clk);
        in1[0] = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1;
            if (out1 !== 32'h0 || rise1 !== 32'h0 || fall1 !== 32'h0 || ch1 !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL glitch_short got %0d active cycles exp 0", bad); end
        @(negedge clk);
        in1[0] = 1'b1;
        repeat (4) @(negedge clk);
        in1[0] = 1'b0;
        n_rise = 0; n_fall = 0; t_rise = -1; t_fall = -1;
        for (int t = 1; t <= 16; t++) begin
            @(posedge clk); #1;
            if (rise1[0]) begin n_rise++; t_rise = t; end
            if (fall1[0]) begin n_fall++; t_fall = t; end
            if ((rise1 | fall1) & 32'hFFFF_FFFE) n_rise += 100;
        end
        n_checks++;
        if (n_rise != 1 || t_rise != 3) begin n_fail++; $display("FAIL glitch_long_rise got count %0d tick %0d exp count 1 tick 3", n_rise, t_rise); end
        n_checks++;
        if (n_fall != 1 || t_fall != 7) begin n_fail++; $display("FAIL glitch_long_fall got count %0d tick %0d exp count 1 tick 7", n_fall, t_fall); end
    endtask

    task automatic test_simultaneous;
        int n_ch, t_rise, t_fall, both;
        @(negedge clk);
        in1[1] = 1'b1;
        repeat (10) @(negedge clk);
        n_checks++;
        if (out1 !== 32'h2) begin n_fail++; $display("FAIL simul_setup got %h exp %h", out1, 32'h2); end
        in1[0] = 1'b1;
        in1[1] = 1'b0;
        n_ch = 0; t_rise = -1; t_fall = -1; both = 0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            if (ch1) n_ch++;
            if (rise1[0]) t_rise = e;
            if (fall1[1]) t_fall = e;
            if (rise1 & fall1) both++;
        end
        n_checks++;
        if (t_rise != 6 || t_fall != 6) begin n_fail++; $display("FAIL simul_edges got rise edge %0d fall edge %0d exp 6 6", t_rise, t_fall); end
        n_checks++;
        if (n_ch != 1 || both != 0) begin n_fail++; $display("FAIL simul_changed got %0d changed cycles %0d overlaps exp 1 0", n_ch, both); end
        n_checks++;
        if (out1 !== 32'h1) begin n_fail++; $display("FAIL simul_level got %h exp %h", out1, 32'h1); end
        @(negedge clk);
        in1 = '0;
        repeat (12) @(negedge clk);
    endtask

    task automatic test_reset_midcount;
        logic [31:0] exp_out, exp_rise;
        @(negedge clk);
        in2[2] = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out2 !== 32'h0 || out0 !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL midcount_pre got out2 %h out0 %h exp %h %h", out2, out0, 32'h0, 32'hFFFF_FFFF);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (out0 !== 32'h0 || out2 !== 32'h0 || out3 !== 32'h0000_00F0 || ch0 !== 1'b0) begin
            n_fail++; $display("FAIL midcount_async got out0 %h out2 %h out3 %h ch0 %b exp 0 0 f0 0", out0, out2, out3, ch0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e < 12; e++) begin
            @(posedge clk); #1;
            exp_out  = (e >= 9) ? 32'h4 : 32'h0;
            exp_rise = (e == 9) ? 32'h4 : 32'h0;
            n_checks++;
            if (out2 !== exp_out || rise2 !== exp_rise || fall2 !== 32'h0 || ch2 !== (e == 9)) begin
                n_fail++;
                $display("FAIL midcount_restart edge %0d got out %h rise %h ch %b exp out %h rise %h",
                         e, out2, rise2, ch2, exp_out, exp_rise);
            end
        end
    endtask

    task automatic test_rst_val;
        int bad;
        bad = 0;
        @(negedge clk);
        reset = 1'b1;
        in3 = 32'h0000_00F0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int e = 0; e < 8; e++) begin
            @(posedge clk); #1;
            if (out3 !== 32'h0000_00F0 || rise3 !== 32'h0 || fall3 !== 32'h0 || ch3 !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL rstval_quiet got %0d bad cycles exp 0", bad); end
        @(negedge clk);
        in3 = 32'h0000_000F;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (rise3 !== 32'h0000_000F || fall3 !== 32'h0000_00F0 || out3 !== 32'h0000_000F || ch3 !== 1'b1) begin
            n_fail++; $display("FAIL rstval_swap got rise %h fall %h out %h ch %b exp f f0 f 1", rise3, fall3, out3, ch3);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_simultaneous();
        test_reset_midcount();
        test_rst_val();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
